// File: rtl/cofre_pkg.sv
// Shared definitions for the sequential safe: controller states and
// 7-segment glyphs in {dp,g,f,e,d,c,b,a} order, active-high.
package cofre_pkg;

  typedef enum logic [1:0] {
    FECHADO = 2'd0,
    ABERTO  = 2'd1,
    TRAVADO = 2'd2
  } estado_t;

  localparam logic [7:0] SEG_A = 8'h77;
  localparam logic [7:0] SEG_L = 8'h38;

  localparam logic [7:0] SEG_HEX [0:15] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational glyph selector: hex digit while closed, 'A' when open,
// 'L' during lockout. The parent registers the result.
module decodificador_7seg
  import cofre_pkg::*;
(
  input  logic [3:0] i_codigo,
  input  estado_t    i_modo,
  output logic [7:0] o_segmentos
);

  // Select the glyph for the requested mode
  always_comb begin
    o_segmentos = 8'h00;
    case (i_modo)
      FECHADO: o_segmentos = SEG_HEX[i_codigo];
      ABERTO:  o_segmentos = SEG_A;
      TRAVADO: o_segmentos = SEG_L;
      default: o_segmentos = 8'h00;
    endcase
  end

endmodule

// File: rtl/cofre_sequencial.sv
// Clocked safe controller: checks one attempt per confirm edge, counts
// consecutive failures, enforces a timed lockout and drives LEDs/display.
module cofre_sequencial
  import cofre_pkg::*;
#(
  parameter int LARGURA        = 4,
  parameter int TOLERANCIA     = 3,
  parameter int MAX_TENTATIVAS = 3,
  parameter int TEMPO_TRAVA    = 8,
  parameter int SENHA_INICIAL  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LARGURA-1:0] tentativa,
  input  logic               confirmar,
  input  logic               programar,
  input  logic               fechar,
  output logic               led0,
  output logic               led1,
  output logic               led2,
  output logic               travado,
  output logic [7:0]         display
);

  localparam int LW = LARGURA + 1;
  localparam int TW = (TEMPO_TRAVA > 1) ? $clog2(TEMPO_TRAVA) : 1;

  estado_t            r_estado;
  logic [LARGURA-1:0] r_senha;
  logic [3:0]         r_falhas;
  logic [TW-1:0]      r_timer;
  logic               r_conf_q;

  estado_t            w_estado;
  logic [LARGURA-1:0] w_senha;
  logic [3:0]         w_falhas;
  logic [TW-1:0]      w_timer;
  logic               w_led0;
  logic               w_led1;
  logic               w_led2;
  logic               w_travado;
  logic [3:0]         w_restantes;
  logic [7:0]         w_segmentos;
  logic               w_pulso;
  logic [LW-1:0]      w_a;
  logic [LW-1:0]      w_b;
  logic [LW-1:0]      w_diff;

  assign w_pulso = confirmar & ~r_conf_q;
  assign w_a     = {1'b0, r_senha};
  assign w_b     = {1'b0, tentativa};
  // One extra bit keeps the distance exact across the full code range
  assign w_diff  = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);

  // Next-state and next-output evaluation
  always_comb begin
    w_estado  = r_estado;
    w_senha   = r_senha;
    w_falhas  = r_falhas;
    w_timer   = r_timer;
    w_led0    = led0;
    w_led1    = led1;
    w_led2    = led2;
    w_travado = travado;
    case (r_estado)
      FECHADO: begin
        if (w_pulso) begin
          if (w_diff == LW'(0)) begin
            w_estado = ABERTO;
            w_led0   = 1'b1;
            w_led1   = 1'b0;
            w_led2   = 1'b0;
            w_falhas = 4'd0;
          end else begin
            w_led2 = 1'b1;
            w_led1 = (w_diff <= LW'(TOLERANCIA));
            if (r_falhas + 4'd1 == 4'(MAX_TENTATIVAS)) begin
              w_estado  = TRAVADO;
              w_timer   = TW'(TEMPO_TRAVA - 1);
              w_travado = 1'b1;
              w_falhas  = 4'd0;
            end else begin
              w_falhas = r_falhas + 4'd1;
            end
          end
        end else begin
          w_estado = FECHADO;
        end
      end
      ABERTO: begin
        w_led0 = 1'b1;
        if (fechar) begin
          w_estado = FECHADO;
          w_led0   = 1'b0;
          w_led1   = 1'b0;
          w_led2   = 1'b0;
        end else if (w_pulso && programar) begin
          w_senha = tentativa;
        end else begin
          w_senha = r_senha;
        end
      end
      TRAVADO: begin
        if (r_timer == TW'(0)) begin
          w_estado  = FECHADO;
          w_travado = 1'b0;
          w_led1    = 1'b0;
          w_led2    = 1'b0;
        end else begin
          w_timer = r_timer - TW'(1);
        end
      end
      default: begin
        w_estado = FECHADO;
      end
    endcase
  end

  assign w_restantes = 4'(MAX_TENTATIVAS) - w_falhas;

  decodificador_7seg u_display (
    .i_codigo    (w_restantes),
    .i_modo      (w_estado),
    .o_segmentos (w_segmentos)
  );

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= FECHADO;
      r_senha  <= LARGURA'(SENHA_INICIAL);
      r_falhas <= 4'd0;
      r_timer  <= TW'(0);
      r_conf_q <= 1'b0;
      led0     <= 1'b0;
      led1     <= 1'b0;
      led2     <= 1'b0;
      travado  <= 1'b0;
      display  <= SEG_HEX[MAX_TENTATIVAS];
    end else begin
      r_estado <= w_estado;
      r_senha  <= w_senha;
      r_falhas <= w_falhas;
      r_timer  <= w_timer;
      r_conf_q <= confirmar;
      led0     <= w_led0;
      led1     <= w_led1;
      led2     <= w_led2;
      travado  <= w_travado;
      display  <= w_segmentos;
    end
  end

endmodule

// File: tb/tb_cofre_sequencial.sv
// Scoreboard bench for cofre_sequencial: directed plan plus random traffic,
// checked cycle by cycle against a behavioural model of the safe.
module tb_cofre_sequencial;

  localparam int L      = 4;
  localparam int TOL    = 3;
  localparam int MAXT   = 3;
  localparam int TEMPO  = 8;
  localparam int SENHA0 = 5;

  localparam logic [7:0] GLYPH [0:15] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };
  localparam logic [7:0] GLYPH_OPEN = 8'h77;
  localparam logic [7:0] GLYPH_LOCK = 8'h38;

  logic         clk = 1'b0;
  logic         reset;
  logic [L-1:0] tentativa;
  logic         confirmar;
  logic         programar;
  logic         fechar;
  logic         led0, led1, led2, travado;
  logic [7:0]   display;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q [$];

  // Model state: mode 0 = closed, 1 = open, 2 = locked
  int m_mode, m_pw, m_fails, m_lock_left;
  bit m_prev_conf, m_l0, m_l1, m_l2, m_trav;

  cofre_sequencial #(
    .LARGURA(L), .TOLERANCIA(TOL), .MAX_TENTATIVAS(MAXT),
    .TEMPO_TRAVA(TEMPO), .SENHA_INICIAL(SENHA0)
  ) dut (
    .clk(clk), .reset(reset), .tentativa(tentativa), .confirmar(confirmar),
    .programar(programar), .fechar(fechar), .led0(led0), .led1(led1),
    .led2(led2), .travado(travado), .display(display)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got led0..2=%b%b%b trav=%b disp=%h, expected led0..2=%b%b%b trav=%b disp=%h",
               name, $time, act[11], act[10], act[9], act[8], act[7:0],
               exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  function automatic logic [11:0] model_outputs();
    logic [7:0] g;
    if (m_mode == 1) g = GLYPH_OPEN;
    else if (m_mode == 2) g = GLYPH_LOCK;
    else g = GLYPH[MAXT - m_fails];
    return {m_l0, m_l1, m_l2, m_trav, g};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pw = SENHA0; m_fails = 0; m_lock_left = 0;
    m_prev_conf = 0; m_l0 = 0; m_l1 = 0; m_l2 = 0; m_trav = 0;
  endtask

  // One clock of the safe's rules as seen from the user's side
  task automatic model_step();
    bit edge_s;
    int d;
    if (reset) begin
      model_reset();
      return;
    end
    edge_s = confirmar && !m_prev_conf;
    m_prev_conf = confirmar;
    if (m_mode == 2) begin
      m_lock_left--;
      if (m_lock_left == 0) begin
        m_mode = 0; m_trav = 0; m_l1 = 0; m_l2 = 0;
      end
    end else if (m_mode == 1) begin
      if (fechar) begin
        m_mode = 0; m_l0 = 0; m_l1 = 0; m_l2 = 0;
      end else if (edge_s && programar) begin
        m_pw = int'(tentativa);
      end
    end else if (edge_s) begin
      d = m_pw - int'(tentativa);
      if (d < 0) d = -d;
      if (d == 0) begin
        m_mode = 1; m_l0 = 1; m_l1 = 0; m_l2 = 0; m_fails = 0;
      end else begin
        m_l2 = 1;
        m_l1 = (d <= TOL);
        m_fails++;
        if (m_fails == MAXT) begin
          m_mode = 2; m_lock_left = TEMPO; m_trav = 1; m_fails = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic [L-1:0] t, input logic c, input logic p, input logic f);
    @(negedge clk);
    #1;
    tentativa = t; confirmar = c; programar = p; fechar = f;
    model_step();
    exp_q.push_back(model_outputs());
  endtask

  task automatic attempt(input logic [L-1:0] t);
    drive(t, 1'b1, 1'b0, 1'b0);
    drive(t, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check(name, {led0, led1, led2, travado, display}, model_outputs());
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // Monitor: compare the registered outputs once per cycle, away from the edge
  always @(negedge clk) begin : monitor
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle", {led0, led1, led2, travado, display}, e);
    end
  end

  initial begin
    reset = 1'b1; tentativa = '0; confirmar = 1'b0; programar = 1'b0; fechar = 1'b0;
    model_reset();
    #1;
    check("reset_state", {led0, led1, led2, travado, display}, model_outputs());
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle(3);

    attempt(4'h5);
    drive(4'h0, 1'b0, 1'b0, 1'b1);
    idle(1);

    attempt(4'h7);
    for (int k = 0; k < 5; k++) drive(4'hF, 1'b1, 1'b0, 1'b0);
    drive(4'hF, 1'b0, 1'b0, 1'b0);

    attempt(4'h8);
    attempt(4'h0);
    attempt(4'h2);
    attempt(4'h5);
    idle(8);
    attempt(4'h5);
    drive(4'h0, 1'b0, 1'b0, 1'b1);

    attempt(4'h5);
    drive(4'hA, 1'b1, 1'b1, 1'b0);
    drive(4'hA, 1'b0, 1'b0, 1'b0);
    drive(4'h0, 1'b0, 1'b0, 1'b1);
    attempt(4'h5);
    attempt(4'hA);
    drive(4'h3, 1'b1, 1'b1, 1'b1);
    drive(4'h3, 1'b0, 1'b0, 1'b0);
    attempt(4'hA);

    attempt(4'h3);
    async_reset("reset_open");
    attempt(4'h5);
    drive(4'h0, 1'b0, 1'b0, 1'b1);
    attempt(4'h0);
    attempt(4'hF);
    attempt(4'h9);
    idle(3);
    async_reset("reset_lock");
    attempt(4'h5);
    drive(4'h0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 400; k++) begin
      logic [L-1:0] t;
      t = ($urandom_range(0, 3) == 0) ? L'(m_pw) : L'($urandom);
      drive(t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
